// File: rtl/dpram_tdp.sv
// True dual-port RAM with byte strobes, per-port write mode, optional output register,
// post-reset clear engine and same-address collision flag. A read issued in cycle c shows dout/vld in c+1 (c+2 with OUT_REG).
`timescale 1ns/1ps
module dpram_tdp #(
  parameter int DATA_W       = 32,
  parameter int DEPTH        = 2048,
  parameter int OUT_REG      = 0,
  parameter int WR_MODE_A    = 0,
  parameter int WR_MODE_B    = 0,
  parameter int CLEAR_ON_RST = 1,
  localparam int NB          = DATA_W / 8,
  localparam int AW          = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena,
  input  logic              wea,
  input  logic [NB-1:0]     wema,
  input  logic [AW-1:0]     addra,
  input  logic [DATA_W-1:0] dina,
  output logic [DATA_W-1:0] douta,
  output logic              douta_vld,
  input  logic              enb,
  input  logic              web,
  input  logic [NB-1:0]     wemb,
  input  logic [AW-1:0]     addrb,
  input  logic [DATA_W-1:0] dinb,
  output logic [DATA_W-1:0] doutb,
  output logic              doutb_vld,
  output logic              init_busy,
  output logic              collision,
  output logic [0:0]        dbg_state
);

  typedef enum logic {S_INIT = 1'b0, S_RUN = 1'b1} state_e;

  state_e                       state_q;
  logic [AW-1:0]                clr_cnt_q;
  logic                         init_busy_q;
  logic [DATA_W-1:0]            mem [DEPTH];

  logic                         act_a, act_b, in_a, in_b, wr_a, wr_b, col_d;
  logic [DATA_W-1:0]            old_a, old_b, merged_a, merged_b;
  logic [1:0]                   vld_d, s1_vld_q;
  logic [1:0][DATA_W-1:0]       rdat_d, s1_dat_q;
  logic                         col_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= (CLEAR_ON_RST != 0) ? S_INIT : S_RUN;
      clr_cnt_q   <= '0;
      init_busy_q <= (CLEAR_ON_RST != 0);
    end else begin
      case (state_q)
        S_INIT: begin
          if (clr_cnt_q == AW'(DEPTH - 1)) begin
            state_q     <= S_RUN;
            init_busy_q <= 1'b0;
          end else begin
            clr_cnt_q <= clr_cnt_q + 1'b1;
          end
        end
        default: state_q <= S_RUN;
      endcase
    end
  end

  // A write with no byte strobes is treated as a plain read.
  assign act_a = (state_q == S_RUN) && ena;
  assign act_b = (state_q == S_RUN) && enb;
  assign in_a  = ({1'b0, addra} < (AW + 1)'(DEPTH));
  assign in_b  = ({1'b0, addrb} < (AW + 1)'(DEPTH));
  assign wr_a  = act_a && wea && (|wema);
  assign wr_b  = act_b && web && (|wemb);
  assign old_a = in_a ? mem[addra] : '0;
  assign old_b = in_b ? mem[addrb] : '0;

  always_comb begin
    merged_a = old_a;
    merged_b = old_b;
    for (int i = 0; i < NB; i++) begin
      if (wema[i]) merged_a[8*i +: 8] = dina[8*i +: 8];
      if (wemb[i]) merged_b[8*i +: 8] = dinb[8*i +: 8];
    end
  end

  assign rdat_d[0] = (wr_a && WR_MODE_A == 1) ? merged_a : old_a;
  assign rdat_d[1] = (wr_b && WR_MODE_B == 1) ? merged_b : old_b;
  assign vld_d[0]  = act_a && !(wr_a && WR_MODE_A == 2);
  assign vld_d[1]  = act_b && !(wr_b && WR_MODE_B == 2);
  assign col_d     = act_a && act_b && (addra == addrb) && (wr_a || wr_b) && in_a;

  // Port B is applied after port A so B owns bytes both ports strobe.
  always_ff @(posedge clk) begin
    if (state_q == S_INIT) begin
      mem[clr_cnt_q] <= '0;
    end else begin
      for (int i = 0; i < NB; i++)
        if (wr_a && in_a && wema[i]) mem[addra][8*i +: 8] <= dina[8*i +: 8];
      for (int i = 0; i < NB; i++)
        if (wr_b && in_b && wemb[i]) mem[addrb][8*i +: 8] <= dinb[8*i +: 8];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_vld_q <= '0;
      s1_dat_q <= '0;
      col_q    <= 1'b0;
    end else begin
      col_q <= col_d;
      for (int p = 0; p < 2; p++) begin
        s1_vld_q[p] <= vld_d[p];
        if (vld_d[p]) s1_dat_q[p] <= rdat_d[p];
      end
    end
  end

  generate
    if (OUT_REG != 0) begin : g_oreg
      logic [1:0]             s2_vld_q;
      logic [1:0][DATA_W-1:0] s2_dat_q;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          s2_vld_q <= '0;
          s2_dat_q <= '0;
        end else begin
          for (int p = 0; p < 2; p++) begin
            s2_vld_q[p] <= s1_vld_q[p];
            if (s1_vld_q[p]) s2_dat_q[p] <= s1_dat_q[p];
          end
        end
      end
      assign douta     = s2_dat_q[0];
      assign doutb     = s2_dat_q[1];
      assign douta_vld = s2_vld_q[0];
      assign doutb_vld = s2_vld_q[1];
    end else begin : g_noreg
      assign douta     = s1_dat_q[0];
      assign doutb     = s1_dat_q[1];
      assign douta_vld = s1_vld_q[0];
      assign doutb_vld = s1_vld_q[1];
    end
  endgenerate

  assign init_busy = init_busy_q;
  assign collision = col_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_dpram_tdp.sv
// Bench for dpram_tdp: two instances (no output register / output register with DEPTH=12),
// reference memory model feeding per-port expected queues, collision queue and init timing checks.
`timescale 1ns/1ps
module tb_dpram_tdp;

  typedef struct packed {
    logic        en;
    logic        we;
    logic [3:0]  wem;
    logic [3:0]  addr;
    logic [31:0] din;
  } port_t;

  localparam int OREG[2]   = '{0, 1};
  localparam int MODE_A[2] = '{1, 0};
  localparam int MODE_B[2] = '{0, 2};
  localparam int DEP[2]    = '{16, 12};

  logic        clk, rst;
  port_t       pa[2], pb[2];
  logic [31:0] dout_w[4];
  logic        vld_w[4];
  logic        busy_w[2], col_w[2];
  logic [0:0]  st_w[2];

  int          n_checks, n_fail, cyc;
  logic        busy_mdl;
  logic [31:0] mdl [2][16];
  logic [31:0] last [4];
  logic [31:0] exp_q [4][$];
  int          exp_cyc_q [4][$];
  int          col_q [2][$];

  dpram_tdp #(.DATA_W(32), .DEPTH(16), .OUT_REG(0), .WR_MODE_A(1), .WR_MODE_B(0), .CLEAR_ON_RST(1)) u_dut0 (
    .clk(clk), .rst(rst),
    .ena(pa[0].en), .wea(pa[0].we), .wema(pa[0].wem), .addra(pa[0].addr), .dina(pa[0].din),
    .douta(dout_w[0]), .douta_vld(vld_w[0]),
    .enb(pb[0].en), .web(pb[0].we), .wemb(pb[0].wem), .addrb(pb[0].addr), .dinb(pb[0].din),
    .doutb(dout_w[1]), .doutb_vld(vld_w[1]),
    .init_busy(busy_w[0]), .collision(col_w[0]), .dbg_state(st_w[0])
  );

  dpram_tdp #(.DATA_W(32), .DEPTH(12), .OUT_REG(1), .WR_MODE_A(0), .WR_MODE_B(2), .CLEAR_ON_RST(1)) u_dut1 (
    .clk(clk), .rst(rst),
    .ena(pa[1].en), .wea(pa[1].we), .wema(pa[1].wem), .addra(pa[1].addr), .dina(pa[1].din),
    .douta(dout_w[2]), .douta_vld(vld_w[2]),
    .enb(pb[1].en), .web(pb[1].we), .wemb(pb[1].wem), .addrb(pb[1].addr), .dinb(pb[1].din),
    .doutb(dout_w[3]), .doutb_vld(vld_w[3]),
    .init_busy(busy_w[1]), .collision(col_w[1]), .dbg_state(st_w[1])
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] d, input logic [3:0] m);
    for (int i = 0; i < 4; i++) if (m[i]) o[8*i +: 8] = d[8*i +: 8];
    return o;
  endfunction

  task automatic push_exp(input int s, input logic wr, input int mode, input logic [31:0] old,
                          input logic [31:0] mrg, input int lat);
    if (!(wr && mode == 2)) begin
      exp_q[s].push_back((wr && mode == 1) ? mrg : old);
      exp_cyc_q[s].push_back(cyc + lat);
    end
  endtask

  // driver: present one cycle of traffic on instance inst, the other instance idles
  task automatic acc(input int inst,
                     input logic ea, input logic wa, input logic [3:0] wma, input logic [3:0] aa, input logic [31:0] da,
                     input logic eb, input logic wb, input logic [3:0] wmb, input logic [3:0] ab, input logic [31:0] db);
    logic [31:0] old_a, old_b;
    logic        wr_a, wr_b, ok_a, ok_b;
    @(negedge clk);
    pa[inst]     = '{ea, wa, wma, aa, da};
    pb[inst]     = '{eb, wb, wmb, ab, db};
    pa[1 - inst] = '0;
    pb[1 - inst] = '0;
    if (!busy_mdl) begin
      ok_a  = int'(aa) < DEP[inst];
      ok_b  = int'(ab) < DEP[inst];
      old_a = ok_a ? mdl[inst][aa] : 32'h0;
      old_b = ok_b ? mdl[inst][ab] : 32'h0;
      wr_a  = wa && (wma != 4'h0);
      wr_b  = wb && (wmb != 4'h0);
      if (ea) push_exp(inst*2,     wr_a, MODE_A[inst], old_a, merge(old_a, da, wma), 1 + OREG[inst]);
      if (eb) push_exp(inst*2 + 1, wr_b, MODE_B[inst], old_b, merge(old_b, db, wmb), 1 + OREG[inst]);
      if (ea && eb && aa == ab && (wr_a || wr_b) && ok_a) col_q[inst].push_back(cyc + 1);
      if (ea && wr_a && ok_a) mdl[inst][aa] = merge(mdl[inst][aa], da, wma);
      if (eb && wr_b && ok_b) mdl[inst][ab] = merge(mdl[inst][ab], db, wmb);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) acc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // scoreboard: pop on every vld, otherwise dout must hold; collision checked every cycle
  always @(negedge clk) begin : mon
    logic [31:0] e;
    int          c;
    for (int s = 0; s < 4; s++) begin
      if (vld_w[s]) begin
        if (exp_q[s].size() == 0) begin
          check($sformatf("spurious_vld s%0d", s), 1, 0);
        end else begin
          e = exp_q[s].pop_front();
          c = exp_cyc_q[s].pop_front();
          check($sformatf("dout s%0d", s), dout_w[s], e);
          check($sformatf("latency s%0d", s), cyc, c);
          last[s] = e;
        end
      end else begin
        check($sformatf("dout_hold s%0d", s), dout_w[s], last[s]);
        if (exp_q[s].size() != 0 && exp_cyc_q[s][0] <= cyc) begin
          check($sformatf("missing_vld s%0d", s), 0, 1);
          void'(exp_q[s].pop_front());
          void'(exp_cyc_q[s].pop_front());
        end
      end
    end
    for (int i = 0; i < 2; i++) begin
      if (col_q[i].size() != 0 && col_q[i][0] == cyc) begin
        check($sformatf("collision i%0d", i), col_w[i], 1);
        void'(col_q[i].pop_front());
      end else begin
        check($sformatf("no_collision i%0d", i), col_w[i], 0);
      end
    end
  end

  initial begin
    for (int s = 0; s < 4; s++) last[s] = '0;
    for (int i = 0; i < 2; i++) for (int a = 0; a < 16; a++) mdl[i][a] = '0;
    busy_mdl = 1'b1;
    pa[0] = '0; pa[1] = '0; pb[0] = '0; pb[1] = '0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_busy0", busy_w[0], 1);
    check("rst_busy1", busy_w[1], 1);
    check("rst_state0", st_w[0], 0);
    rst = 1'b0;
    // reset again in the middle of the clear: busy must last a full DEPTH from here
    repeat (5) @(negedge clk);
    check("mid_init_busy0", busy_w[0], 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("init_busy0 k0", busy_w[0], 1);
    check("init_busy1 k0", busy_w[1], 1);
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      check($sformatf("init_busy0 k%0d", k), busy_w[0], (k < 16) ? 1 : 0);
      check($sformatf("init_busy1 k%0d", k), busy_w[1], (k < 12) ? 1 : 0);
      if (k == 2) begin
        pa[0] = '{1'b1, 1'b1, 4'hf, 4'd2, 32'hdeadbeef};
        pb[1] = '{1'b1, 1'b1, 4'hf, 4'd1, 32'h0badf00d};
      end
      if (k == 3) begin
        pa[0] = '0;
        pb[1] = '0;
      end
    end
    busy_mdl = 1'b0;

    // cleared contents (includes addresses poked during INIT); back-to-back on the registered instance
    for (int i = 0; i < 16; i++) acc(0, 1, 0, 0, 4'(i), 0, 1, 0, 0, 4'(15 - i), 0);
    for (int i = 0; i < 12; i++) acc(1, 1, 0, 0, 4'(i), 0, 1, 0, 0, 4'(11 - i), 0);

    // byte strobes
    acc(0, 1, 1, 4'hf, 4'd5, 32'h11223344, 0, 0, 0, 0, 0);
    acc(0, 1, 1, 4'h5, 4'd5, 32'haabbccdd, 0, 0, 0, 0, 0);
    acc(0, 1, 0, 4'h0, 4'd5, 32'h0,        0, 0, 0, 0, 0);

    // write modes: read-first, write-first, no-change
    acc(0, 0, 0, 0, 0, 0, 1, 1, 4'hf, 4'd3, 32'hcafef00d);
    acc(0, 1, 1, 4'hf, 4'd4, 32'hcafef00d, 0, 0, 0, 0, 0);
    acc(1, 0, 0, 0, 0, 0, 1, 1, 4'hf, 4'd3, 32'hcafef00d);
    idle(3);
    acc(1, 0, 0, 0, 0, 0, 1, 0, 4'h0, 4'd3, 32'h0);

    // write/write collision, then readback
    acc(0, 1, 1, 4'hf, 4'd7, 32'h11111111, 1, 1, 4'h3, 4'd7, 32'h22222222);
    acc(0, 1, 0, 4'h0, 4'd7, 32'h0, 0, 0, 0, 0, 0);

    // read/write collision
    acc(0, 1, 1, 4'hf, 4'd9, 32'h5, 0, 0, 0, 0, 0);
    acc(0, 1, 0, 4'h0, 4'd9, 32'h0, 1, 1, 4'hf, 4'd9, 32'h9);
    acc(0, 1, 0, 4'h0, 4'd9, 32'h0, 0, 0, 0, 0, 0);

    // write enable with no strobes is a read on both ports: no change, no collision
    acc(0, 1, 1, 4'h0, 4'd5, 32'hffffffff, 1, 1, 4'h0, 4'd5, 32'hffffffff);
    acc(0, 1, 0, 4'h0, 4'd5, 32'h0, 0, 0, 0, 0, 0);

    // out-of-range addresses on the DEPTH=12 instance
    acc(1, 1, 1, 4'hf, 4'd13, 32'h12345678, 1, 1, 4'hf, 4'd13, 32'h87654321);
    acc(1, 1, 0, 4'h0, 4'd13, 32'h0, 1, 0, 4'h0, 4'd14, 32'h0);
    idle(2);

    // random traffic over a narrow address window to provoke collisions
    for (int n = 0; n < 80; n++) begin
      acc(n % 2,
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
          4'($urandom_range(0, 3) + ((n % 2) * 10)), $urandom,
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
          4'($urandom_range(0, 3) + ((n % 2) * 10)), $urandom);
    end
    idle(5);

    for (int s = 0; s < 4; s++) check($sformatf("exp_q_drained s%0d", s), exp_q[s].size(), 0);
    for (int i = 0; i < 2; i++) check($sformatf("col_q_drained i%0d", i), col_q[i].size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
